// File: rtl/aes_disp_pkg.sv
// Shared constants, FSM state type and page-slicing helper for the AES display pager.
package aes_disp_pkg;

  localparam int          NUM_PAGES = 6;
  localparam int          PAGE_W    = 24;
  localparam int          FRAME_W   = 144;
  localparam logic [15:0] PAD       = 16'h0000;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_SHOW_LOCKED = 2'd1,
    ST_SHOW_FREE   = 2'd2
  } state_t;

  // Page p is the 24-bit field starting at frame bit 143-24p; out-of-range pages read as 0.
  function automatic logic [PAGE_W-1:0] page_slice(input logic [FRAME_W-1:0] frame,
                                                   input logic [2:0] p);
    logic [FRAME_W-1:0] sh;
    if (int'(p) >= NUM_PAGES) begin
      return '0;
    end
    sh = frame >> (PAGE_W * (NUM_PAGES - 1 - int'(p)));
    return sh[PAGE_W-1:0];
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchronizer plus stable-time debounce for an active-low push-button.
// Emits a single-cycle pulse when the debounced level falls (a press).
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic pressed
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic          key_p0;
  logic          key_p1;
  logic          key_db;
  logic [CW-1:0] cnt;
  logic          settle;

  // The synchronized level has differed from the debounced one for DEBOUNCE_CYCLES cycles.
  assign settle = (key_p1 != key_db) && (cnt == CW'(DEBOUNCE_CYCLES - 1));

  // Synchronizer stages; released (1) out of reset so no false press appears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_p0 <= 1'b1;
      key_p1 <= 1'b1;
    end else begin
      key_p0 <= key_n;
      key_p1 <= key_p0;
    end
  end

  // Stability counter, debounced level and press pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      key_db  <= 1'b1;
      pressed <= 1'b0;
    end else begin
      pressed <= settle && key_db;
      if (key_p1 == key_db || settle) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
      if (settle) begin
        key_db <= key_p1;
      end
    end
  end

endmodule

// File: rtl/aes_display_pager.sv
// Pages a 128-bit AES block across six 24-bit hex pages for a 6-digit display.
// disp_value feeds the hex-mode 7-segment digit driver directly.
module aes_display_pager
  import aes_disp_pkg::*;
#(
  parameter int PAGE_CYCLES     = 50_000_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         key_next_n,
  input  logic         auto_en,
  output logic [23:0]  disp_value,
  output logic [2:0]   page,
  output logic         locked
);

  localparam int TW = (PAGE_CYCLES > 1) ? $clog2(PAGE_CYCLES) : 1;

  state_t               state_q;
  state_t               state_d;
  logic [FRAME_W-1:0]   frame_q;
  logic [FRAME_W-1:0]   frame_d;
  logic [2:0]           page_d;
  logic [TW-1:0]        timer_q;
  logic                 key_pressed;
  logic                 show;
  logic                 transfer;
  logic                 expire;
  logic                 advance;
  logic                 wrap;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key (
    .clk    (clk),
    .rst_n  (rst_n),
    .key_n  (key_next_n),
    .pressed(key_pressed)
  );

  assign show     = (state_q != ST_IDLE);
  assign transfer = in_valid && in_ready;
  assign expire   = show && auto_en && (timer_q == TW'(PAGE_CYCLES - 1));
  // Key and timer are OR-ed so a coincident pair still gives one advance.
  assign advance  = show && (key_pressed || expire);
  assign wrap     = (page == 3'(NUM_PAGES - 1));

  // Next frame and page: a transfer always wins over an advance.
  always_comb begin
    frame_d = frame_q;
    page_d  = page;
    if (transfer) begin
      frame_d = {in_data, PAD};
      page_d  = '0;
    end else if (advance) begin
      page_d = wrap ? 3'd0 : page + 3'd1;
    end
  end

  // Frame, page and display registers (one cycle behind the transfer edge).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_q    <= '0;
      page       <= '0;
      disp_value <= '0;
    end else begin
      frame_q    <= frame_d;
      page       <= page_d;
      disp_value <= page_slice(frame_d, page_d);
    end
  end

  // Dwell timer: runs only while showing with auto_en, restarts on any page change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q <= '0;
    end else if (!show || !auto_en || advance || transfer) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_q + 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake/lock outputs.
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b1;
    locked   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (transfer) state_d = ST_SHOW_LOCKED;
      end
      ST_SHOW_LOCKED: begin
        in_ready = 1'b0;
        locked   = 1'b1;
        if (advance && wrap) state_d = ST_SHOW_FREE;
      end
      ST_SHOW_FREE: begin
        if (transfer) state_d = ST_SHOW_LOCKED;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: doc/aes_display_pager.md
AES_DISPLAY_PAGER -- requirements
Module: aes_display_pager

Interface
REQ-001 Parameter PAGE_CYCLES, default 50_000_000, sets the auto-advance dwell in clk cycles (1 s at 50 MHz).
REQ-002 Parameter DEBOUNCE_CYCLES, default 1_000_000, sets the key-stable time in clk cycles (20 ms).
REQ-003 clk  input  1  system clock, 50 MHz; the only clock.
REQ-004 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-005 in_valid  input  1  AES result block is offered.
REQ-006 in_ready  output  1  pager can accept a block.
REQ-007 in_data  input  128  AES ciphertext/plaintext block; bit 127 is the MSB.
REQ-008 key_next_n  input  1  raw push-button, active-low, asynchronous to clk.
REQ-009 auto_en  input  1  enables timed page advance.
REQ-010 disp_value  output  24  six-hex-digit value sent to the 7-segment driver (hex mode).
REQ-011 page  output  3  index of the displayed page, 0..5.
REQ-012 locked  output  1  high while the current block has not yet been shown in full.

Function
REQ-013 The block SHALL transfer data on a clk edge where in_valid and in_ready are both 1; no other edge transfers.
REQ-014 On transfer, the block SHALL store {in_data, 16'h0000} as a 144-bit frame.
- Page p SHALL equal frame[143-24p : 120-24p].
- Page 5 therefore holds in_data[7:0] followed by 16'h0000.
REQ-015 The FSM SHALL have states IDLE, SHOW_LOCKED and SHOW_FREE; the state encoding lives in the package.
REQ-016 IDLE: in_ready=1, locked=0, disp_value=0, page=0; a transfer moves the FSM to SHOW_LOCKED.
REQ-017 SHOW_LOCKED: in_ready=0, locked=1; advancing from page 5 to page 0 moves the FSM to SHOW_FREE.
REQ-018 SHOW_FREE: in_ready=1, locked=0; a transfer reloads the frame, sets page=0 and returns to SHOW_LOCKED.
REQ-019 disp_value and page SHALL be registered and SHALL reflect a new transfer on the clk edge after the transfer edge (1-cycle latency).
REQ-020 An advance event SHALL move page from p to (p+1) mod 6; page SHALL never take the values 6 or 7.
REQ-021 An advance event is either of:
- a debounced key press (falling edge of the synchronized, debounced key), or
- a dwell-timer expiry while auto_en=1.
REQ-022 Dwell timer:
- counts 0..PAGE_CYCLES-1 only while in a SHOW state with auto_en=1;
- expires at PAGE_CYCLES-1;
- clears on any advance, any transfer, and whenever auto_en=0.
REQ-023 A key press and a timer expiry in the same cycle SHALL produce exactly one advance.
REQ-024 A transfer and an advance in the same cycle SHALL resolve as transfer wins: page=0, the advance is discarded.
REQ-025 Advance events in IDLE SHALL be ignored.
REQ-026 key_next_n SHALL pass through a 2-flop synchronizer.
- Its debounced level SHALL change only after the synchronized level has stayed stable for DEBOUNCE_CYCLES consecutive cycles.
- A press SHALL yield exactly one single-cycle pulse.

Reset
REQ-027 While rst_n=0, the block SHALL hold:
- FSM=IDLE, frame=0, page=0, disp_value=0;
- in_ready=1 after reset release, locked=0;
- timers cleared, debounced key level=1 (released).
REQ-028 Reset asserted mid-display SHALL abandon the frame, and no stale page SHALL appear after release.

Structure
REQ-029 Package aes_disp_pkg SHALL hold:
- NUM_PAGES=6, PAGE_W=24, PAD=16'h0000;
- the FSM state typedef.
REQ-030 Key synchronization and debounce SHALL be the sub-module key_debounce (clk, rst_n, key_n, pressed pulse).
REQ-031 disp_value SHALL connect directly to disp_value of drive_6dig_7segs with hex_mode tied to 1.

Verification (PAGE_CYCLES=8, DEBOUNCE_CYCLES=4)
REQ-032 The bench SHALL cover the following directed scenarios:
- Transfer 128'h0123456789abcdef0123456789abcdef with auto_en=1 -> pages read 012345, 6789ab, cdef01, 234567, 89abcd, ef0000, each held 8 cycles; in_ready=0 until the page 5->0 wrap, then 1.
- In_valid held in SHOW_LOCKED -> no transfer; in_ready=0; frame unchanged.
- Key pulsed low for 2 cycles -> no advance; key held low 10 cycles -> exactly one advance, visible about 6-7 cycles after the edge.
- Key press coinciding with timer expiry -> page advances by 1, not 2.
- In SHOW_FREE at page 3, transfer coinciding with timer expiry -> next cycle page=0 with the new data; locked=1.
- rst_n dropped at page 2 asynchronously -> disp_value=0 and page=0 immediately; in_ready=1 after release.
